// File: rtl/stage2_seq_pkg.sv
// Shared definitions for the stage-2 convolution frame sequencer:
// FSM state encoding, default frame geometry and derived widths.
package stage2_seq_pkg;

   // Default frame geometry
   localparam int ST2_COL = 12;
   localparam int ST2_ROW = 12;
   localparam int ST2_K   = 5;

   // Output plane produced by a valid (unpadded) KxK convolution
   localparam int ST2_OUT_ROWS = ST2_ROW - ST2_K + 1;
   localparam int ST2_OUT_COLS = ST2_COL - ST2_K + 1;
   localparam int ST2_OUT_N    = ST2_OUT_ROWS * ST2_OUT_COLS;

   // Derived widths
   localparam int ST2_ADDR_W = $clog2(ST2_ROW * ST2_COL);
   localparam int ST2_CRD_W  = $clog2(ST2_OUT_ROWS);
   localparam int ST2_CNT_W  = $clog2(ST2_OUT_N + 1);

   // Sequencer states
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FEED  = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/stage2_seq_out_tag.sv
// Output-point counter and row/column tagger for the stage-2 sequencer.
// Registers the core's output-valid and tags each flagged point with its
// (row, col) coordinate; the coordinate advances after the flagged cycle.
module stage2_seq_out_tag
   import stage2_seq_pkg::*;
#(
   parameter int OUT_ROWS = ST2_OUT_ROWS,
   parameter int OUT_COLS = ST2_OUT_COLS,
   parameter int OUT_N    = ST2_OUT_N,
   parameter int CRD_W    = ST2_CRD_W,
   parameter int CNT_W    = ST2_CNT_W
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             i_clr,
   input  logic             i_en,
   input  logic             i_core_ot_valid,
   output logic             o_ot_valid,
   output logic [CNT_W-1:0] o_cnt,
   output logic [CRD_W-1:0] o_row,
   output logic [CRD_W-1:0] o_col,
   output logic             o_last
);

   localparam logic [CRD_W-1:0] COL_LAST = CRD_W'(OUT_COLS - 1);
   localparam logic [CRD_W-1:0] ROW_LAST = CRD_W'(OUT_ROWS - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OUT_N - 1);

   // The point being counted on this edge is the final one of the frame
   assign o_last = o_ot_valid && i_en && (o_cnt == CNT_LAST);

   // Delay the core strobe one cycle, then count and advance the coordinate
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         o_ot_valid <= 1'b0;
         o_cnt      <= '0;
         o_row      <= '0;
         o_col      <= '0;
      end else begin
         o_ot_valid <= i_core_ot_valid;
         if (i_clr) begin
            o_cnt <= '0;
            o_row <= '0;
            o_col <= '0;
         end else if (o_ot_valid && i_en) begin
            o_cnt <= o_cnt + CNT_W'(1);
            if (o_col == COL_LAST) begin
               o_col <= '0;
               o_row <= (o_row == ROW_LAST) ? '0 : o_row + CRD_W'(1);
            end else begin
               o_col <= o_col + CRD_W'(1);
            end
         end
      end
   end

endmodule

// File: rtl/stage2_conv_seq.sv
// Frame sequencer for the stage-2 5x5 convolution core.
// Streams one ROWxCOLxCI frame from the frame buffer into the core as a
// gap-free run of valid pixels, then waits for all output points, tagging
// each with its output row/column, and pulses o_done.
// Optional build macro: ST2_SEQ_WATCHDOG_EN enables a DRAIN watchdog that
// flags o_err and forces completion after DRAIN_MAX cycles in DRAIN.
module stage2_conv_seq
   import stage2_seq_pkg::*;
#(
   parameter int COL       = ST2_COL,
   parameter int ROW       = ST2_ROW,
   parameter int K         = ST2_K,
   parameter int CI        = 3,
   parameter int IBW       = 20,
   parameter int BANKS     = 4,
   parameter int DRAIN_MAX = 64
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic                           i_start,
   input  logic [$clog2(BANKS)-1:0]       i_bank,
   output logic                           o_busy,
   output logic                           o_done,
   output logic                           o_err,
   output logic                           o_rd_en,
   output logic [$clog2(ROW*COL)-1:0]     o_rd_addr,
   input  logic [CI*IBW-1:0]              i_rd_data,
   output logic                           o_core_valid,
   output logic [CI*IBW-1:0]              o_core_fmap,
   output logic [$clog2(BANKS)-1:0]       o_wgt_bank,
   input  logic                           i_core_ot_valid,
   output logic                           o_ot_valid,
   output logic [$clog2(ROW-K+1)-1:0]     o_ot_row,
   output logic [$clog2(ROW-K+1)-1:0]     o_ot_col
);

   localparam int ADDR_W   = $clog2(ROW * COL);
   localparam int CRD_W    = $clog2(ROW - K + 1);
   localparam int OUT_ROWS = ROW - K + 1;
   localparam int OUT_COLS = COL - K + 1;
   localparam int OUT_N    = OUT_ROWS * OUT_COLS;
   localparam int CNT_W    = $clog2(OUT_N + 1);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ROW * COL - 1);

   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic             start_acc;
   logic             rd_en_d1;
   logic             tag_en;
   logic             tag_last;
   logic [CNT_W-1:0] tag_cnt;
   logic             drain_done;
   logic             wd_expire;

   assign start_acc  = (state == ST_IDLE) && i_start;
   assign tag_en     = (state == ST_FEED) || (state == ST_DRAIN);
   assign drain_done = tag_last || (tag_cnt == CNT_W'(OUT_N));
   assign o_busy     = (state != ST_IDLE);
   assign o_done     = (state == ST_DONE);

`ifdef ST2_SEQ_WATCHDOG_EN
   localparam int WD_W = $clog2(DRAIN_MAX + 1);
   logic [WD_W-1:0] wd_cnt;

   // Count cycles spent in DRAIN; restart whenever DRAIN is left
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)             wd_cnt <= '0;
      else if (state == ST_DRAIN) wd_cnt <= wd_cnt + WD_W'(1);
      else                      wd_cnt <= '0;
   end

   assign wd_expire = (state == ST_DRAIN) && !drain_done &&
                      (wd_cnt == WD_W'(DRAIN_MAX - 1));
`else
   assign wd_expire = 1'b0;
`endif

   // Next-state decode for the frame sequence
   // NOTE: state_nxt takes a default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (i_start)                    state_nxt = ST_FEED;
         ST_FEED:  if (o_rd_addr == LAST_ADDR)     state_nxt = ST_DRAIN;
         ST_DRAIN: if (drain_done || wd_expire)    state_nxt = ST_DONE;
         ST_DONE:                                  state_nxt = ST_IDLE;
         default:                                  state_nxt = ST_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   // Read-address generator and weight-bank latch
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         o_rd_en    <= 1'b0;
         o_rd_addr  <= '0;
         o_wgt_bank <= '0;
      end else if (start_acc) begin
         o_rd_en    <= 1'b1;
         o_rd_addr  <= '0;
         o_wgt_bank <= i_bank;
      end else if (state == ST_FEED) begin
         if (o_rd_addr == LAST_ADDR) o_rd_en   <= 1'b0;
         else                        o_rd_addr <= o_rd_addr + ADDR_W'(1);
      end
   end

   // Pixel path: buffer data lands one cycle after the read, then registered
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_en_d1     <= 1'b0;
         o_core_valid <= 1'b0;
         o_core_fmap  <= '0;
      end else begin
         rd_en_d1     <= o_rd_en;
         o_core_valid <= rd_en_d1;
         o_core_fmap  <= i_rd_data;
      end
   end

   // Sticky error: stray core output while idle, or watchdog expiry
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                                   o_err <= 1'b0;
      else if (start_acc)                             o_err <= 1'b0;
      else if ((state == ST_IDLE) && i_core_ot_valid) o_err <= 1'b1;
      else if (wd_expire)                             o_err <= 1'b1;
   end

   stage2_seq_out_tag #(
      .OUT_ROWS (OUT_ROWS),
      .OUT_COLS (OUT_COLS),
      .OUT_N    (OUT_N),
      .CRD_W    (CRD_W),
      .CNT_W    (CNT_W)
   ) u_out_tag (
      .clk             (clk),
      .reset_n         (reset_n),
      .i_clr           (start_acc),
      .i_en            (tag_en),
      .i_core_ot_valid (i_core_ot_valid),
      .o_ot_valid      (o_ot_valid),
      .o_cnt           (tag_cnt),
      .o_row           (o_ot_row),
      .o_col           (o_ot_col),
      .o_last          (tag_last)
   );

endmodule

// File: doc/stage2_conv_seq.md
# stage2_conv_seq

Frame sequencer for the stage-2 5x5 convolution core. On a start pulse it streams one complete 12x12x3 input feature map from the stage-2 frame buffer into the core as a gap-free run of valid pixels. It then counts the 64 expected output points, tags each with its output row and column, and signals completion. It sits between the stage-1 output buffer (read port) and the convolution core (pixel input and valid-output monitor).

## Interface
Parameters:
- `COL`, 12, input frame width
- `ROW`, 12, input frame height
- `K`, 5, kernel size
- `CI`, 3, input channels
- `IBW`, 20, bits per channel per pixel
- `BANKS`, 4, number of selectable weight/bias banks
- `DRAIN_MAX`, 64, watchdog limit in DRAIN cycles (used only with the macro below)

Ports:
- `clk`, in, 1, single clock; all logic on the rising edge
- `reset_n`, in, 1, asynchronous active-low reset
- `i_start`, in, 1, start-frame pulse; accepted only in IDLE
- `i_bank`, in, clog2(BANKS), weight bank for the frame; latched on an accepted start
- `o_busy`, out, 1, high in every state except IDLE
- `o_done`, out, 1, one-cycle pulse at end of frame
- `o_err`, out, 1, sticky error flag; cleared on an accepted start
- `o_rd_en`, out, 1, frame-buffer read enable
- `o_rd_addr`, out, clog2(ROW*COL), pixel address in row-major order
- `i_rd_data`, in, CI*IBW, read data, valid one cycle after `o_rd_en`
- `o_core_valid`, out, 1, pixel valid to the core
- `o_core_fmap`, out, CI*IBW, pixel to the core; channel k at bits [k*IBW +: IBW]
- `o_wgt_bank`, out, clog2(BANKS), latched bank; held stable while busy
- `i_core_ot_valid`, in, 1, output-valid from the core
- `o_ot_valid`, out, 1, registered copy of `i_core_ot_valid` for tagging
- `o_ot_row`, `o_ot_col`, out, clog2(ROW-K+1) each, coordinates of the current output point

## Operation
- States: IDLE, FEED, DRAIN, DONE.
- IDLE, with `i_start` high:
  - latch `i_bank`
  - clear `o_err`, the address counter and the output counter
  - go to FEED
- `i_start` in any other state is ignored.
- FEED:
  - assert `o_rd_en` every cycle, with `o_rd_addr` running 0..ROW*COL-1 (0..143)
  - after address 143 is issued, go to DRAIN
  - the feed never pauses, because the core's window logic requires contiguous valid pixels
- Pixel path:
  - `o_core_fmap` is `i_rd_data` registered
  - `o_core_valid` is `o_rd_en` delayed by two cycles
  - exactly 144 valid pixels reach the core per frame
- Output tagging: each `i_core_ot_valid` pulse
  - increments `o_ot_col`
  - when `o_ot_col` wraps from 7 to 0, increments `o_ot_row`
  - the output counter counts to OUT_N = (ROW-K+1)*(COL-K+1) = 64
  - `o_ot_row`/`o_ot_col` present the coordinates of the point flagged in the same cycle by `o_ot_valid`, then advance
- DRAIN: stay until the output counter reaches 64, then go to DONE. Outputs arriving during FEED are also counted.
- DONE: pulse `o_done` for one cycle, return to IDLE.
- `i_core_ot_valid` in IDLE (unexpected output) sets `o_err`; the counters are not changed.
- More than 64 outputs in one frame is impossible by construction, because DONE is entered on the 64th.

## Timing
- Reset values:
  - state IDLE
  - `o_busy`, `o_done`, `o_err`, `o_rd_en`, `o_core_valid`, `o_ot_valid` = 0
  - `o_rd_addr`, `o_core_fmap`, `o_wgt_bank`, `o_ot_row`, `o_ot_col` = 0
- Start accepted at edge T:
  - `o_busy` and `o_rd_en` high from T+1
  - first `o_core_valid` at T+3
  - last `o_rd_en` at T+144; last `o_core_valid` at T+146
- `o_ot_valid` lags `i_core_ot_valid` by one cycle.
- `o_done` is asserted the cycle after the edge that counts the 64th output. `o_busy` drops together with `o_done` falling, so back-to-back starts are possible from the cycle `o_busy` is low.
- Reset mid-frame:
  - all outputs return to their reset values asynchronously
  - the frame is abandoned
  - the core must be reset together with this block (shared `reset_n`) so its row/col counters stay aligned

## Configuration
- `ST2_SEQ_WATCHDOG_EN` defined:
  - a DRAIN cycle counter runs
  - if `DRAIN_MAX` cycles pass in DRAIN without reaching 64 outputs, set `o_err`, go to DONE and pulse `o_done`
- Undefined: no counter; DRAIN waits indefinitely and `DRAIN_MAX` is unused.

## Structure
- Shared package `stage2_seq_pkg`:
  - state encoding (IDLE=0, FEED=1, DRAIN=2, DONE=3)
  - OUT_N and the address/coordinate width constants derived from ROW, COL and K
- One sub-module, `stage2_seq_out_tag`: the output counter and row/col tagger, with `i_core_ot_valid` in and count, row, col and done-count out.

## Test plan
- Reset, then start with `i_bank`=2 and a core model emitting 64 outputs:
  - exactly 144 `o_core_valid` pulses with addresses 0..143 in order and data matching the buffer
  - `o_wgt_bank`=2 throughout
  - `o_done` pulses once and `o_err`=0
- Tagging: outputs 0, 7, 8 and 63 tag as (0,0), (0,7), (1,0) and (7,7).
- Start pulses during FEED and during DRAIN are ignored: the address sequence is unbroken and there is still a single `o_done`.
- Unexpected `i_core_ot_valid` in IDLE sets `o_err`=1; the next accepted start clears it to 0.
- `reset_n` low at address 70:
  - all outputs reach reset values immediately
  - a new start restarts from address 0 and completes normally
- With `ST2_SEQ_WATCHDOG_EN` and a core model emitting only 60 outputs: `o_err`=1 and `o_done` pulses exactly `DRAIN_MAX` cycles after entering DRAIN.
